// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state types for the bus UART.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_RX_FERR  = 4;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_bus_resp_fifo.sv
// First-word-fall-through synchronous FIFO; push to full and pop from empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_dat   = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_dat;
  end

endmodule

// File: rtl/uart_bus_resp.sv
// Bus target exposing an 8N1 UART: DATA/STATUS/DIVISOR registers, one-cycle ack on every access.
//
// state     | meaning
// IDLE      | TX: waiting for a queued byte / RX: waiting for a 1->0 on the line
// START     | start bit (RX samples it at divisor/2 to reject glitches)
// DATA      | eight data bits, LSB first
// STOP      | stop bit; RX pushes or flags the frame here
module uart_bus_resp
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_dat_w,
  input  logic [3:0]  i_we,
  input  logic        i_stb,
  output logic [31:0] o_dat_r,
  output logic        o_ack,
  output logic        o_tx,
  input  logic        i_rx
);

  localparam logic [15:0] RST_DIV = 16'(CLK_HZ / BAUD);

  logic        ack_q, ack_d;
  logic [31:0] dat_r_q, dat_r_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;

  tx_state_e   tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;

  logic        tx_push, tx_pop, tx_full, tx_fempty;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_full, rx_fempty;
  logic [7:0]  rx_head;

  logic [1:0]  reg_sel;
  logic        is_rd, status_rd, ovr_set, ferr_set;
  logic [31:0] status_vec, rd_val;
  logic        unused_bits;

  assign unused_bits = ^{i_addr[31:4], i_addr[1:0], i_dat_w[31:16]};
  assign o_ack   = ack_q;
  assign o_dat_r = dat_r_q;
  assign o_tx    = tx_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(tx_push), .i_dat(i_dat_w[7:0]),
    .i_pop(tx_pop), .o_dat(tx_head), .o_full(tx_full), .o_empty(tx_fempty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(rx_push), .i_dat(rx_sh_q),
    .i_pop(rx_pop), .o_dat(rx_head), .o_full(rx_full), .o_empty(rx_fempty)
  );

  always_comb begin
    reg_sel   = i_addr[3:2];
    is_rd     = i_stb && (i_we == 4'b0000);
    status_rd = is_rd && (reg_sel == REG_STATUS);
    tx_push   = i_stb && (reg_sel == REG_DATA) && i_we[0];
    rx_pop    = is_rd && (reg_sel == REG_DATA) && !rx_fempty;

    status_vec              = '0;
    status_vec[ST_TX_FULL]  = tx_full;
    status_vec[ST_TX_EMPTY] = tx_fempty && (tx_st_q == TX_IDLE);
    status_vec[ST_RX_VALID] = !rx_fempty;
    status_vec[ST_RX_OVR]   = ovr_q;
    status_vec[ST_RX_FERR]  = ferr_q;

    case (reg_sel)
      REG_DATA:   rd_val = rx_fempty ? 32'h0 : {23'b0, 1'b1, rx_head};
      REG_STATUS: rd_val = status_vec;
      REG_DIV:    rd_val = {16'b0, div_q};
      default:    rd_val = 32'h0;
    endcase

    ack_d   = i_stb;
    dat_r_d = is_rd ? rd_val : 32'h0;

    div_d = div_q;
    if (i_stb && (reg_sel == REG_DIV) && (i_we[1:0] == 2'b11))
      div_d = (i_dat_w[15:0] < MIN_DIV) ? MIN_DIV : i_dat_w[15:0];
  end

  // Every TX state lasts div_q clocks; div_q is re-read at each bit boundary.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      TX_IDLE: begin
        if (!tx_fempty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_head;
          tx_cnt_d = div_q - 16'd1;
          tx_st_d  = TX_START;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_st_d  = TX_DATA;
          tx_cnt_d = div_q - 16'd1;
          tx_bit_d = 3'd0;
          tx_d     = tx_sh_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: begin
        if (tx_cnt_q == '0) begin
          if (!tx_fempty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_head;
            tx_cnt_d = div_q - 16'd1;
            tx_st_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            tx_st_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase
  end

  // A low line after a framing error never shows a 1->0, so RX re-arms only once it goes high.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = (div_q >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) rx_st_d = RX_IDLE;
          else begin
            rx_st_d  = RX_DATA;
            rx_cnt_d = div_q - 16'd1;
            rx_bit_d = 3'd0;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_st_d = RX_IDLE;
          if (!rx_sync_q) ferr_set = 1'b1;
          else if (rx_full) ovr_set = 1'b1;
          else rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
    endcase

    ovr_d  = (ovr_q && !status_rd) || ovr_set;
    ferr_d = (ferr_q && !status_rd) || ferr_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q     <= 1'b0;
      dat_r_q   <= 32'h0;
      div_q     <= RST_DIV;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      tx_st_q   <= TX_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 1'b1;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_r_q   <= dat_r_d;
      div_q     <= div_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_d;
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_resp.sv
// Directed + randomized bench for uart_bus_resp against a queue-based model of the UART registers.
module tb_uart_bus_resp;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 16;
  localparam int DIV    = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_addr = '0;
  logic [31:0] i_dat_w = '0;
  logic [3:0]  i_we = '0;
  logic        i_stb = 1'b0;
  logic [31:0] o_dat_r;
  logic        o_ack;
  logic        o_tx;
  logic        i_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  byte unsigned rxq[$];
  bit           m_ovr = 1'b0;
  bit           m_ferr = 1'b0;
  byte unsigned tx_seen[$];
  bit           mon_stop_err = 1'b0;

  always #5 i_clk = ~i_clk;

  uart_bus_resp #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_dat_w(i_dat_w), .i_we(i_we),
    .i_stb(i_stb), .o_dat_r(o_dat_r), .o_ack(o_ack), .o_tx(o_tx), .i_rx(i_rx)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [1:0] r, input logic [3:0] we, input logic [31:0] wd,
                      output logic [31:0] rd);
    i_addr = {28'h0, r, 2'b00};
    i_we = we;
    i_dat_w = wd;
    i_stb = 1'b1;
    cyc(1);
    i_stb = 1'b0;
    i_we = 4'b0000;
    check("ack", 32'(o_ack), 32'd1);
    rd = o_dat_r;
    cyc(1);
    check("ack_single", 32'(o_ack), 32'd0);
    check("dat_r_idle", o_dat_r, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] d;
    xfer(r, 4'b0000, 32'h0, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] r, input logic [3:0] we, input logic [31:0] wd);
    logic [31:0] d;
    xfer(r, we, wd, d);
    check("wr_dat_r", d, 32'h0);
  endtask

  function automatic logic [31:0] exp_status();
    return {27'b0, m_ferr, m_ovr, (rxq.size() != 0), 1'b1, 1'b0};
  endfunction

  task automatic status_chk(input string tag);
    rd_chk(tag, 2'd1, exp_status());
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic data_rd_chk(input string tag);
    logic [31:0] e;
    if (rxq.size() > 0) e = {23'b0, 1'b1, rxq.pop_front()};
    else e = 32'h0;
    rd_chk(tag, 2'd0, e);
  endtask

  // Drives one 8N1 frame plus one idle bit and applies the frame to the model.
  task automatic send_rx(input byte unsigned b, input bit stop_ok);
    i_rx = 1'b0;
    cyc(DIV);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      cyc(DIV);
    end
    i_rx = stop_ok;
    cyc(DIV);
    i_rx = 1'b1;
    cyc(DIV);
    if (!stop_ok) m_ferr = 1'b1;
    else if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  initial begin : tx_mon
    byte unsigned b;
    b = 8'h00;
    forever begin
      cyc(1);
      if (o_tx === 1'b0) begin
        cyc(DIV / 2);
        if (o_tx !== 1'b0) mon_stop_err = 1'b1;
        for (int k = 0; k < 8; k++) begin
          cyc(DIV);
          b[k] = o_tx;
        end
        cyc(DIV);
        if (o_tx !== 1'b1) mon_stop_err = 1'b1;
        tx_seen.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]   pat;
    bit           ok, found;
    logic         expb;
    byte unsigned txb[17];
    byte unsigned exp_tx[$];
    int           cnt;
    bit           popped;

    i_rst = 1'b1;
    cyc(3);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_dat_r", o_dat_r, 32'h0);
    check("rst_tx", 32'(o_tx), 32'd1);
    i_rst = 1'b0;
    cyc(1);

    rd_chk("rst_data", 2'd0, 32'h0);
    status_chk("rst_status");
    rd_chk("rst_div", 2'd2, 32'(CLK_HZ / BAUD));
    rd_chk("reg3_read", 2'd3, 32'h0);
    check("idle_tx", 32'(o_tx), 32'd1);

    wr(2'd2, 4'b0011, 32'h0000_0002);
    rd_chk("div_min_clamp", 2'd2, 32'd4);
    wr(2'd2, 4'b0001, 32'h0000_0040);
    rd_chk("div_partial_we", 2'd2, 32'd4);
    wr(2'd2, 4'b0011, 32'h0000_0010);
    rd_chk("div_16", 2'd2, 32'd16);
    wr(2'd1, 4'b1111, 32'hFFFF_FFFF);
    wr(2'd3, 4'b1111, 32'hFFFF_FFFF);
    status_chk("status_wr_ignored");

    // Single TX frame, checked on every clock of every bit.
    pat = 8'h55;
    wr(2'd0, 4'b0001, {24'h0, pat});
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (o_tx === 1'b0) found = 1'b1;
      else cyc(1);
    end
    check("tx_start_seen", 32'(found), 32'd1);
    for (int bi = 0; bi < 10; bi++) begin
      expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : pat[bi-1];
      ok = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        if (o_tx !== expb) ok = 1'b0;
        cyc(1);
      end
      check($sformatf("tx_bit%0d", bi), 32'(ok), 32'd1);
    end
    status_chk("tx_done_status");

    send_rx(8'hA3, 1'b1);
    status_chk("rx_valid_status");
    data_rd_chk("rx_a3");
    data_rd_chk("rx_empty_after_a3");

    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom_range(255, 0)), 1'b1);
    status_chk("rx_overrun_status");
    status_chk("rx_overrun_cleared");
    for (int i = 0; i < DEPTH; i++) data_rd_chk($sformatf("rx_fifo_%0d", i));
    data_rd_chk("rx_drained");

    send_rx(8'($urandom_range(255, 0)), 1'b0);
    status_chk("rx_frame_err_status");
    data_rd_chk("rx_frame_err_nothing");

    i_rx = 1'b0;
    cyc(2);
    i_rx = 1'b1;
    cyc(40);
    status_chk("rx_glitch_status");
    data_rd_chk("rx_glitch_nothing");

    // Back-to-back DATA writes, each strobe in the previous ack cycle.
    tx_seen.delete();
    mon_stop_err = 1'b0;
    cnt = 0;
    popped = 1'b0;
    for (int i = 0; i < 17; i++) begin
      txb[i] = 8'($urandom_range(255, 0));
      if (cnt < DEPTH) exp_tx.push_back(txb[i]);
      if (i >= 1 && !popped && cnt > 0) begin
        cnt--;
        popped = 1'b1;
      end
      if (cnt < DEPTH) cnt++;
    end
    i_addr = 32'h0;
    i_we = 4'b0001;
    i_stb = 1'b1;
    for (int i = 0; i < 17; i++) begin
      i_dat_w = {24'h0, txb[i]};
      cyc(1);
      check($sformatf("burst_ack_%0d", i), 32'(o_ack), 32'd1);
      check("burst_dat_r", o_dat_r, 32'h0);
    end
    i_stb = 1'b0;
    i_we = 4'b0000;
    cyc(1);
    check("burst_ack_end", 32'(o_ack), 32'd0);
    for (int t = 0; t < 4000 && tx_seen.size() < exp_tx.size(); t++) cyc(1);
    check("tx_byte_count", 32'(tx_seen.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
      check($sformatf("tx_byte_%0d", i), 32'(tx_seen[i]), 32'(exp_tx[i]));
    check("tx_stop_bits", 32'(mon_stop_err), 32'd0);
    cyc(2 * DIV);
    status_chk("tx_burst_done_status");

    // Reset in the middle of a frame of zeros.
    wr(2'd0, 4'b0001, 32'h0000_0000);
    cyc(40);
    check("tx_mid_frame_low", 32'(o_tx), 32'd0);
    i_rst = 1'b1;
    cyc(1);
    check("tx_abort_high", 32'(o_tx), 32'd1);
    i_rst = 1'b0;
    rxq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    cyc(1);
    rd_chk("div_after_reset", 2'd2, 32'(CLK_HZ / BAUD));
    status_chk("status_after_reset");
    check("tx_idle_after_reset", 32'(o_tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
